song_reader: RTL and testbench
==============================

# song_reader

Sequencer directly upstream of `note_player`. It walks a song stored in a synchronous ROM and presents one note (pitch code plus duration in 1/48 s beats) at a time with a one-cycle load pulse. It then waits for the player's done indication before fetching the next note. It flags end of song so the top-level control can stop or re-arm playback.

## Interface
Parameters:
- `IDX_W`, default 5: note-index width; a song holds up to 2^IDX_W notes.

Ports:
- `clk`, input, 1: system clock, the only clock.
- `reset`, input, 1: synchronous, active-high.
- `play`, input, 1: high means advance; low freezes the FSM and holds all outputs.
- `song`, input, 2: selected song number.
- `note_done`, input, 1: level from `note_player` `done_with_note`.
- `note`, output, 6: pitch code, connects to `note_to_load`.
- `duration`, output, 6: beats, connects to `duration_to_load`.
- `new_note`, output, 1: one-cycle load strobe, connects to `load_new_note`.
- `song_done`, output, 1: level, high once the song has ended.
- `note_index`, output, IDX_W: index of the current note, for display.

## Operation
- ROM word is 12 bits, `{note[11:6], duration[5:0]}`, at address `{song_q, note_index}`. Synchronous read: data is valid the cycle after the address is presented.
- A word with duration == 0 is the end-of-song marker and is never issued to the player.
- `song_q` is a registered copy of `song`. Whenever `song != song_q`, in any state and regardless of `play`:
  - `song_q <= song`, `note_index <= 0`, `song_done <= 0`, state <= FETCH.
  - `note` and `duration` hold their values.
- States:
  - FETCH: address presented. Goes to WAIT_ROM.
  - WAIT_ROM: ROM data valid. If duration == 0, go to DONE. Otherwise latch `note`/`duration` from the ROM and go to LOAD.
  - LOAD: `new_note` = 1. Goes to WAIT_DONE.
  - WAIT_DONE: sample `note_done`.
    - On 1 with `note_index` == 2^IDX_W−1, go to DONE.
    - On 1 otherwise, `note_index` += 1 and go to FETCH.
    - On 0, stay.
  - DONE: `song_done` = 1. Stay until a song change or reset.
- All transitions except song change and reset require `play` = 1. With `play` = 0 the state, index and outputs hold, and `new_note` = 0.
- `note_done` is ignored outside WAIT_DONE. The player's counter clears on the edge ending LOAD, so a stale `note_done` from the previous note is never seen.
- Reset:
  - state FETCH, `note_index` 0, `song_q` <= `song`.
  - `note` 0, `duration` 0, `new_note` 0, `song_done` 0.
  - Reset mid-note simply restarts the song.

## Timing
- After reset or a song change, with `play` high: FETCH at cycle 0, WAIT_ROM at 1, `new_note` high at cycle 2 with `note`/`duration` already valid in that cycle.
- `note_done` seen high in WAIT_DONE at cycle k: next `new_note` at cycle k+3. The inter-note gap is 3 cycles.
- `new_note` is exactly one cycle wide per note and never asserts twice without an intervening WAIT_DONE exit.
- End marker: `song_done` rises 2 cycles after FETCH of the marker word, with no `new_note`.
- Last slot (index 2^IDX_W−1): `song_done` rises the cycle after `note_done` is accepted. The index does not wrap.
- Song change and `play` falling in the same cycle: the song change wins and the FSM then freezes in FETCH.
- All outputs are registered except `new_note`, which is decoded from state & `play`.

## Structure
- Shared header `song_defs.vh`:
  - NOTE_W = 6, DUR_W = 6, SONG_W = 2.
  - ROM word layout and field slices.
  - State encodings: FETCH, WAIT_ROM, LOAD, WAIT_DONE, DONE.
- One sub-module, `song_rom`: `clk`, `addr[SONG_W+IDX_W-1:0]`, `dout[11:0]`, synchronous read, contents from an init file.
- The index counter and registers use the existing `dffre`/`dffr` flops.

## Test plan
- Reset, `play` = 1, song 0 = {(note 10, dur 4), (note 20, dur 2), marker}: `new_note` at cycle 2 with note 10 / dur 4. Drive `note_done` at cycle 8 → `new_note` at cycle 11 with note 20 / dur 2. After the next `note_done`, `song_done` rises and `new_note` stays 0.
- `note_done` held high through LOAD and the first WAIT_DONE entry → exactly one `new_note` per note, and `note_index` advances by one per accepted `note_done`.
- `play` dropped for 10 cycles in each of FETCH, WAIT_ROM and WAIT_DONE → outputs and `note_index` frozen. Resuming gives identical subsequent timing shifted by 10 cycles.
- Song 1 filled with 32 nonzero notes → 32 `new_note` pulses, `note_index` reaches 31 with no wrap, and `song_done` is asserted 1 cycle after the final `note_done`.
- `song` changed 0→2 while in WAIT_DONE at index 5 → next cycle FETCH with index 0 and `song_done` 0. `new_note` carries song 2, word 0, 2 cycles later.
- `reset` asserted in WAIT_DONE and in DONE → all outputs 0 the next cycle, then the song restarts from index 0.

Source files
------------

// File: rtl/song_reader_pkg.sv
// Shared widths, ROM word layout, FSM encoding and the song table for song_reader.
// The song table is a constant function so the ROM elaborates without an init file.
package song_reader_pkg;
  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;
  localparam int SONG_W = 2;
  localparam int WORD_W = NOTE_W + DUR_W;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } rom_word_t;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_WAIT_ROM,
    ST_LOAD,
    ST_WAIT_DONE,
    ST_DONE
  } state_t;

  // dur == 0 is the end-of-song marker; unlisted slots read as markers.
  function automatic rom_word_t song_word(input logic [SONG_W-1:0] song,
                                          input logic [15:0]       idx);
    rom_word_t w;
    w = '0;
    case (song)
      2'd0: begin
        case (idx)
          16'd0:   w = '{note: 6'd10, dur: 6'd4};
          16'd1:   w = '{note: 6'd20, dur: 6'd2};
          default: w = '0;
        endcase
      end
      2'd1: begin
        if (idx < 16'd32) begin
          w.note = NOTE_W'(idx + 16'd1);
          w.dur  = DUR_W'((idx << 1) + 16'd1);
        end
      end
      2'd2: begin
        case (idx)
          16'd0:   w = '{note: 6'd7, dur: 6'd9};
          16'd1:   w = '{note: 6'd8, dur: 6'd3};
          16'd2:   w = '{note: 6'd9, dur: 6'd1};
          default: w = '0;
        endcase
      end
      default: w = '0;
    endcase
    return w;
  endfunction
endpackage

// File: rtl/song_reader_rom.sv
// Synchronous-read song ROM: dout is valid the cycle after addr is presented.
module song_rom
  import song_reader_pkg::*;
#(
  parameter int IDX_W = 5
) (
  input  logic                    clk,
  input  logic [SONG_W+IDX_W-1:0] addr,
  output logic [WORD_W-1:0]       dout
);
  always_ff @(posedge clk) begin
    dout <= song_word(addr[SONG_W+IDX_W-1 -: SONG_W], 16'(addr[IDX_W-1:0]));
  end
endmodule

// File: rtl/song_reader.sv
// Walks the selected song one note at a time, strobing each note into the player
// and waiting for its done level before fetching the next word.
module song_reader
  import song_reader_pkg::*;
#(
  parameter int IDX_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic [SONG_W-1:0] song,
  input  logic              note_done,
  output logic [NOTE_W-1:0] note,
  output logic [DUR_W-1:0]  duration,
  output logic              new_note,
  output logic              song_done,
  output logic [IDX_W-1:0]  note_index
);
  state_t            state, state_nxt;
  logic [SONG_W-1:0] song_q;
  logic [WORD_W-1:0] rom_dout;
  rom_word_t         rom_w;
  logic              song_chg, last_idx;
  logic              ld_word, inc_idx, set_done;

  assign song_chg = (song != song_q);
  assign last_idx = (note_index == '1);
  assign rom_w    = rom_word_t'(rom_dout);
  assign new_note = (state == ST_LOAD) && play;

  // Address is held steady while frozen, so ROM data stays valid in WAIT_ROM.
  song_rom #(.IDX_W(IDX_W)) u_rom (
    .clk  (clk),
    .addr ({song_q, note_index}),
    .dout (rom_dout)
  );

  always_comb begin
    state_nxt = state;
    ld_word   = 1'b0;
    inc_idx   = 1'b0;
    set_done  = 1'b0;
    if (song_chg) begin
      state_nxt = ST_FETCH;
    end else if (play) begin
      case (state)
        ST_FETCH:    state_nxt = ST_WAIT_ROM;
        ST_WAIT_ROM: begin
          if (rom_w.dur == '0) begin
            state_nxt = ST_DONE;
            set_done  = 1'b1;
          end else begin
            state_nxt = ST_LOAD;
            ld_word   = 1'b1;
          end
        end
        ST_LOAD:     state_nxt = ST_WAIT_DONE;
        ST_WAIT_DONE: begin
          if (note_done) begin
            if (last_idx) begin
              state_nxt = ST_DONE;
              set_done  = 1'b1;
            end else begin
              state_nxt = ST_FETCH;
              inc_idx   = 1'b1;
            end
          end
        end
        ST_DONE:     state_nxt = ST_DONE;
        default:     state_nxt = ST_FETCH;
      endcase
    end
  end

  // Song change outranks play; note/duration keep their last values across it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_FETCH;
      song_q     <= song;
      note_index <= '0;
      note       <= '0;
      duration   <= '0;
      song_done  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (song_chg) begin
        song_q     <= song;
        note_index <= '0;
        song_done  <= 1'b0;
      end else begin
        if (inc_idx)  note_index <= note_index + IDX_W'(1);
        if (set_done) song_done  <= 1'b1;
        if (ld_word) begin
          note     <= rom_w.note;
          duration <= rom_w.dur;
        end
      end
    end
  end
endmodule

// File: tb/tb_song_reader.sv
// Directed bench for song_reader: a per-cycle reference model built from the song
// tables plus literal checks at hand-computed cycles.
module tb_song_reader;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       play = 1'b1;
  logic [1:0] song = 2'd0;
  logic       note_done = 1'b0;
  logic [5:0] note, duration;
  logic       new_note, song_done;
  logic [4:0] note_index;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  bit en = 1'b0;

  song_reader #(.IDX_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .play       (play),
    .song       (song),
    .note_done  (note_done),
    .note       (note),
    .duration   (duration),
    .new_note   (new_note),
    .song_done  (song_done),
    .note_index (note_index)
  );

  always #5 clk = ~clk;

  // Song contents as the player should hear them; duration 0 ends the song.
  function automatic void tbl(input int s, input int i, output int n, output int d);
    n = 0; d = 0;
    if (s == 0) begin
      if (i == 0) begin n = 10; d = 4; end
      else if (i == 1) begin n = 20; d = 2; end
    end else if (s == 1) begin
      if (i < 32) begin n = i + 1; d = 2 * i + 1; end
    end else if (s == 2) begin
      if (i == 0) begin n = 7; d = 9; end
      else if (i == 1) begin n = 8; d = 3; end
      else if (i == 2) begin n = 9; d = 1; end
    end
  endfunction

  // m_age counts play-enabled cycles since the current word's fetch began:
  // word is known after 1, strobe lands at 2, done is accepted from 3 onward.
  int m_song = 0, m_idx = 0, m_note = 0, m_dur = 0, m_age = 0;
  bit m_done = 1'b0;

  always @(posedge clk) begin : model
    int n, d;
    if (reset) begin
      m_song = int'(song); m_idx = 0; m_note = 0; m_dur = 0; m_done = 1'b0; m_age = 0;
    end else if (int'(song) != m_song) begin
      m_song = int'(song); m_idx = 0; m_done = 1'b0; m_age = 0;
    end else if (play && !m_done) begin
      if (m_age == 1) begin
        tbl(m_song, m_idx, n, d);
        if (d == 0) m_done = 1'b1;
        else begin m_note = n; m_dur = d; m_age = 2; end
      end else if (m_age < 3) begin
        m_age++;
      end else if (note_done) begin
        if (m_idx == 31) m_done = 1'b1;
        else begin m_idx++; m_age = 0; end
      end
    end
  end

  always @(negedge clk) begin : compare
    bit exp_nn;
    if (en) begin
      exp_nn = (m_age == 2) && !m_done && play;
      checks++;
      if (note !== 6'(m_note) || duration !== 6'(m_dur) || new_note !== exp_nn ||
          song_done !== m_done || note_index !== 5'(m_idx)) begin
        errors++;
        $display("FAIL model t=%0t got note=%0d dur=%0d new=%0b done=%0b idx=%0d want note=%0d dur=%0d new=%0b done=%0b idx=%0d",
                 $time, note, duration, new_note, song_done, note_index,
                 m_note, m_dur, exp_nn, m_done, m_idx);
      end
      pulses += int'(new_note);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, exp);
    end
  endtask

  initial begin
    // reset, then song 0: strobe at cycle 2, note_done at 8, next strobe at 11
    tick();
    en = 1'b1;
    chk("rst_note", note, 0);
    chk("rst_dur", duration, 0);
    chk("rst_new", new_note, 0);
    chk("rst_done", song_done, 0);
    chk("rst_idx", note_index, 0);
    reset = 1'b0;
    tick(2);
    chk("s0_new_c2", new_note, 1);
    chk("s0_note_c2", note, 10);
    chk("s0_dur_c2", duration, 4);
    tick(6);
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
    chk("s0_idx_c9", note_index, 1);
    tick(2);
    chk("s0_new_c11", new_note, 1);
    chk("s0_note_c11", note, 20);
    chk("s0_dur_c11", duration, 2);
    tick();
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
    tick(2);
    chk("s0_done_c15", song_done, 1);
    chk("s0_new_c15", new_note, 0);
    tick(5);
    chk("s0_done_hold", song_done, 1);
    chk("s0_note_hold", note, 20);

    // song 2 with note_done held high: one strobe per note, 3 notes
    song = 2'd2; note_done = 1'b1; pulses = 0;
    tick();
    tick(20);
    chk("s2_pulses", pulses, 3);
    chk("s2_idx", note_index, 3);
    chk("s2_done", song_done, 1);

    // play dropped for 10 cycles in FETCH, WAIT_ROM and WAIT_DONE
    song = 2'd0; note_done = 1'b0;
    tick();
    play = 1'b0;
    tick(10);
    chk("frz_fetch_idx", note_index, 0);
    chk("frz_fetch_new", new_note, 0);
    play = 1'b1;
    tick();
    play = 1'b0;
    tick(10);
    play = 1'b1;
    tick();
    chk("frz_load_new", new_note, 1);
    chk("frz_load_note", note, 10);
    tick();
    play = 1'b0; note_done = 1'b1;
    tick(10);
    chk("frz_wd_idx", note_index, 0);
    play = 1'b1;
    tick();
    note_done = 1'b0;
    chk("frz_resume_idx", note_index, 1);

    // song 1: 32 notes, last index does not wrap
    song = 2'd1; note_done = 1'b1; pulses = 0;
    tick();
    tick(127);
    chk("s1_idx_c127", note_index, 31);
    chk("s1_done_c127", song_done, 0);
    tick();
    chk("s1_done_c128", song_done, 1);
    chk("s1_idx_c128", note_index, 31);
    tick(5);
    chk("s1_pulses", pulses, 32);
    chk("s1_note_last", note, 32);
    chk("s1_dur_last", duration, 63);

    // song 3 is empty: marker at word 0
    song = 2'd3; note_done = 1'b0; pulses = 0;
    tick();
    tick(2);
    chk("s3_done", song_done, 1);
    chk("s3_pulses", pulses, 0);

    // song change 1 -> 2 while waiting at index 5
    song = 2'd1; note_done = 1'b1;
    tick();
    tick(20);
    note_done = 1'b0;
    tick(3);
    chk("chg_idx5", note_index, 5);
    song = 2'd2;
    tick();
    chk("chg_idx0", note_index, 0);
    chk("chg_done0", song_done, 0);
    chk("chg_note_hold", note, 6);
    tick(2);
    chk("chg_new", new_note, 1);
    chk("chg_note", note, 7);
    chk("chg_dur", duration, 9);

    // reset in WAIT_DONE, then in DONE
    tick();
    reset = 1'b1;
    tick();
    chk("rwd_note", note, 0);
    chk("rwd_dur", duration, 0);
    chk("rwd_new", new_note, 0);
    chk("rwd_idx", note_index, 0);
    reset = 1'b0;
    tick(2);
    chk("rwd_restart", note, 7);
    song = 2'd3;
    tick();
    tick(2);
    chk("rdn_pre", song_done, 1);
    reset = 1'b1;
    tick();
    chk("rdn_done", song_done, 0);
    chk("rdn_idx", note_index, 0);
    reset = 1'b0;
    tick(2);
    chk("rdn_again", song_done, 1);

    // song change together with play falling: change wins, then frozen
    song = 2'd0; play = 1'b0;
    tick();
    tick(5);
    chk("chg_frz_new", new_note, 0);
    chk("chg_frz_done", song_done, 0);
    play = 1'b1;
    tick(2);
    chk("chg_frz_resume", new_note, 1);
    chk("chg_frz_note", note, 10);

    tick(2);
    en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
